gpu_ram_arbiter: RTL and testbench

Shares the single GPU RAM host port between NUM_REQ requesters: port 0 is the Z80 bridge, and ports 1..NUM_REQ-1 are the blitter, DMA and auxiliary hosts. Each port issues one-shot `rd_req`/`wr_ena` pulses. The block latches those pulses, arbitrates one RAM command per GPU_CLK, tracks in-flight reads through the RAM read pipeline, and returns a one-shot `rd_rdy` with data to the owning port. The block sits between the host-side bridges and the GPU RAM read/write mux.

---
 rtl/gpu_ram_pkg.sv | 19 +
 rtl/gpu_ram_rr_arbiter.sv | 42 ++++
 rtl/gpu_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_gpu_ram_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_ram_pkg.sv
// Shared constants for the GPU RAM host-port arbiter: port roles, default
// geometry and the width helper used for read tags and round-robin pointers.
package gpu_ram_pkg;

   localparam int PORT_Z80  = 0;
   localparam int PORT_BLIT = 1;
   localparam int PORT_DMA  = 2;
   localparam int PORT_AUX  = 3;

   localparam int DEF_ADDR_W       = 20;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_READ_LATENCY = 2;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpu_ram_rr_arbiter.sv
// Round-robin picker over N request bits: searches from ptr upward with
// wrap-around and returns a one-hot grant plus the slot after the winner.
module gpu_ram_rr_arbiter
   import gpu_ram_pkg::*;
#(
   parameter int N     = 3,
   parameter int PTR_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] ptr_nxt
);

   localparam logic [PTR_W:0] N_L = (PTR_W+1)'(N);

   logic [PTR_W:0] cand;
   logic [PTR_W:0] nxt;
   logic           found;

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      gnt     = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      cand    = '0;
      nxt     = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(i);
         if (cand >= N_L) cand = cand - N_L;
         if (en && !found && req[cand[PTR_W-1:0]]) begin
            found                  = 1'b1;
            gnt[cand[PTR_W-1:0]]   = 1'b1;
            nxt                    = cand + 1'b1;
            if (nxt == N_L) nxt = '0;
            ptr_nxt = nxt[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/gpu_ram_arbiter.sv
// Shares the GPU RAM host port between NUM_REQ requesters: Z80 (port 0) has
// absolute priority, the rest rotate; read data returns to the issuing port.
module gpu_ram_arbiter
   import gpu_ram_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic                      GPU_CLK,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        port_rd_req,
   input  logic [NUM_REQ-1:0]        port_wr_ena,
   input  logic [NUM_REQ*ADDR_W-1:0] port_addr,
   input  logic [NUM_REQ*DATA_W-1:0] port_wdata,
   output logic [NUM_REQ-1:0]        port_rd_rdy,
   output logic [DATA_W-1:0]         port_rd_data,
   output logic [NUM_REQ-1:0]        port_busy,
   output logic [NUM_REQ-1:0]        port_err,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_wdata,
   output logic                      ram_wena,
   output logic                      ram_rd,
   input  logic [DATA_W-1:0]         ram_rdata
);

   localparam int TAG_W = idx_w(NUM_REQ);
   localparam int NRR   = NUM_REQ - 1;
   localparam int PTR_W = idx_w(NRR);

   logic [NUM_REQ-1:0] pend_vld;
   logic [NUM_REQ-1:0] pend_wr;
   logic [ADDR_W-1:0]  pend_addr  [NUM_REQ];
   logic [DATA_W-1:0]  pend_wdata [NUM_REQ];

   logic [NUM_REQ-1:0] in_vld, eff_vld, eff_wr, gnt;
   logic [NUM_REQ-1:0] latch_v, drop_v, collide_v;
   logic [NRR-1:0]     rr_gnt;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;

   logic               sel_any, sel_wr;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic [TAG_W-1:0]   sel_tag;

   logic               pipe_vld [READ_LATENCY+1];
   logic [TAG_W-1:0]   pipe_tag [READ_LATENCY+1];

   // A live pulse is arbitrated in its own cycle; a held slot takes precedence over it.
   assign in_vld  = port_rd_req | port_wr_ena;
   assign eff_vld = pend_vld | in_vld;
   assign eff_wr  = (pend_vld & pend_wr) | (~pend_vld & port_wr_ena);

   gpu_ram_rr_arbiter #(.N(NRR), .PTR_W(PTR_W)) u_rr (
      .req     (eff_vld[NUM_REQ-1:PORT_BLIT]),
      .ptr     (rr_ptr),
      .en      (!eff_vld[PORT_Z80]),
      .gnt     (rr_gnt),
      .ptr_nxt (rr_ptr_nxt)
   );

   assign gnt     = {rr_gnt, eff_vld[PORT_Z80]};
   assign sel_any = |gnt;

   // Latch when the slot frees this cycle or was empty and the pulse lost.
   assign latch_v   = in_vld & ~(gnt ^ pend_vld);
   assign drop_v    = in_vld & pend_vld & ~gnt;
   assign collide_v = port_rd_req & port_wr_ena;
   assign port_busy = pend_vld;

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_tag   = '0;
      for (int p = 0; p < NUM_REQ; p++) begin
         if (gnt[p]) begin
            sel_wr    = eff_wr[p];
            sel_addr  = pend_vld[p] ? pend_addr[p]  : port_addr[p*ADDR_W +: ADDR_W];
            sel_wdata = pend_vld[p] ? pend_wdata[p] : port_wdata[p*DATA_W +: DATA_W];
            sel_tag   = TAG_W'(p);
         end
      end
   end

   // NOTE: slot payload is qualified by pend_vld, so it is deliberately left out of reset.
   always_ff @(posedge GPU_CLK) begin
      for (int p = 0; p < NUM_REQ; p++) begin
         if (latch_v[p]) begin
            pend_wr[p]    <= port_wr_ena[p];
            pend_addr[p]  <= port_addr[p*ADDR_W +: ADDR_W];
            pend_wdata[p] <= port_wdata[p*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: non-blocking throughout, so every register here sees pre-edge values.
   always_ff @(posedge GPU_CLK or posedge reset) begin
      if (reset) begin
         pend_vld     <= '0;
         port_err     <= '0;
         rr_ptr       <= '0;
         ram_rd       <= 1'b0;
         ram_wena     <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         port_rd_rdy  <= '0;
         port_rd_data <= '0;
         for (int k = 0; k <= READ_LATENCY; k++) begin
            pipe_vld[k] <= 1'b0;
            pipe_tag[k] <= '0;
         end
      end else begin
         pend_vld <= (pend_vld & ~gnt) | latch_v;
         port_err <= port_err | drop_v | collide_v;
         rr_ptr   <= rr_ptr_nxt;

         ram_rd   <= sel_any & !sel_wr;
         ram_wena <= sel_any & sel_wr;
         if (sel_any) begin
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
         end

         pipe_vld[0] <= sel_any & !sel_wr;
         pipe_tag[0] <= sel_tag;
         for (int k = 1; k <= READ_LATENCY; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_tag[k] <= pipe_tag[k-1];
         end

         // The last stage lines up with ram_rdata being valid.
         port_rd_rdy <= '0;
         if (pipe_vld[READ_LATENCY]) begin
            port_rd_rdy[pipe_tag[READ_LATENCY]] <= 1'b1;
            port_rd_data                        <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// Self-checking bench for gpu_ram_arbiter: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_gpu_ram_arbiter;
   import gpu_ram_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 20;
   localparam int DATA_W  = 8;
   localparam int RL      = 2;

   logic                      GPU_CLK = 1'b0;
   logic                      reset   = 1'b1;
   logic [NUM_REQ-1:0]        port_rd_req = '0;
   logic [NUM_REQ-1:0]        port_wr_ena = '0;
   logic [NUM_REQ*ADDR_W-1:0] port_addr   = '0;
   logic [NUM_REQ*DATA_W-1:0] port_wdata  = '0;
   logic [NUM_REQ-1:0]        port_rd_rdy, port_busy, port_err;
   logic [DATA_W-1:0]         port_rd_data, ram_wdata;
   logic [ADDR_W-1:0]         ram_addr;
   logic                      ram_wena, ram_rd;
   logic [DATA_W-1:0]         ram_rdata = '0;

   gpu_ram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .READ_LATENCY(RL)) dut (
      .GPU_CLK(GPU_CLK), .reset(reset),
      .port_rd_req(port_rd_req), .port_wr_ena(port_wr_ena),
      .port_addr(port_addr), .port_wdata(port_wdata),
      .port_rd_rdy(port_rd_rdy), .port_rd_data(port_rd_data),
      .port_busy(port_busy), .port_err(port_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wena(ram_wena),
      .ram_rd(ram_rd), .ram_rdata(ram_rdata)
   );

   always #4 GPU_CLK = ~GPU_CLK;

   // RAM model: in-order single port, data READ_LATENCY cycles after ram_rd.
   logic [7:0] ram_mem [logic [19:0]];
   logic [7:0] ram_d1 = '0;

   function automatic logic [7:0] init_byte(input logic [19:0] a);
      return a[7:0] ^ a[19:12] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_peek(input logic [19:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
   endfunction

   always @(posedge GPU_CLK) begin
      if (ram_wena) ram_mem[ram_addr] = ram_wdata;
      ram_d1    <= ram_peek(ram_addr);
      ram_rdata <= ram_d1;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge GPU_CLK);
      #1;
      cyc++;
      port_rd_req = '0;
      port_wr_ena = '0;
   endtask

   task automatic set_port(input int p, input bit rd, input bit wr,
                           input logic [19:0] a, input logic [7:0] d);
      port_rd_req[p]            = rd;
      port_wr_ena[p]            = wr;
      port_addr[p*ADDR_W +: ADDR_W] = a;
      port_wdata[p*DATA_W +: DATA_W] = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      port_rd_req = '0;
      port_wr_ena = '0;
      repeat (2) @(posedge GPU_CLK);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ram_rd"},    ram_rd,       0);
      check({tag, "_ram_wena"},  ram_wena,     0);
      check({tag, "_ram_addr"},  ram_addr,     0);
      check({tag, "_ram_wdata"}, ram_wdata,    0);
      check({tag, "_rd_rdy"},    port_rd_rdy,  0);
      check({tag, "_rd_data"},   port_rd_data, 0);
      check({tag, "_busy"},      port_busy,    0);
      check({tag, "_err"},       port_err,     0);
   endtask

   function automatic logic [19:0] base(input int p);
      return 20'(p + 1) << 8;
   endfunction

   typedef struct {
      logic [3:0]  rd;
      logic [3:0]  wr;
      logic        exp_rd;
      logic        exp_wena;
      logic [19:0] exp_addr;
      logic [7:0]  exp_wdata;
      logic [3:0]  exp_busy;
      logic [3:0]  exp_err;
   } vec_t;

   vec_t vecs [11];

   // Reference model state for the randomized run.
   typedef struct {
      bit          vld;
      bit          wr;
      logic [19:0] addr;
      logic [7:0]  wd;
   } mreq_t;

   typedef struct {
      int         at;
      int         port;
      logic [7:0] data;
   } rsp_t;

   mreq_t      mpend [NUM_REQ];
   bit [3:0]   merr;
   int         last_nz;
   logic [7:0] ref_mem [logic [19:0]];
   rsp_t       rspq [$];

   function automatic logic [7:0] ref_peek(input logic [19:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   order [$];
      int   cnt [NUM_REQ];
      int   grants, pulses, budget, bad;

      ram_mem[20'h12345] = 8'hA5;
      ram_mem[20'h00500] = 8'h61;
      ram_mem[20'h00501] = 8'h62;
      ram_mem[20'h00502] = 8'h63;
      ram_mem[20'h00602] = 8'h77;

      // ---- power-on reset state
      repeat (2) @(posedge GPU_CLK);
      #1;
      check_all_zero("in_reset");
      reset = 1'b0;
      tick();
      check_all_zero("after_reset");

      // ---- vector table: one input cycle, then next-cycle command/busy/err
      vecs[0]  = '{4'b0111, 4'b0000, 1'b1, 1'b0, 20'h00100, 8'h00, 4'b0110, 4'b0000};
      vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 20'h00200, 8'h00, 4'b0100, 4'b0000};
      vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 20'h00300, 8'h00, 4'b0000, 4'b0000};
      vecs[3]  = '{4'b0000, 4'b1000, 1'b0, 1'b1, 20'h00400, 8'h13, 4'b0000, 4'b0000};
      vecs[4]  = '{4'b1110, 4'b0000, 1'b1, 1'b0, 20'h00200, 8'h00, 4'b1100, 4'b0000};
      vecs[5]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 20'h00100, 8'h00, 4'b1100, 4'b0000};
      vecs[6]  = '{4'b1001, 4'b0000, 1'b1, 1'b0, 20'h00100, 8'h00, 4'b1100, 4'b1000};
      vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 20'h00300, 8'h00, 4'b1000, 4'b1000};
      vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 20'h00400, 8'h00, 4'b0000, 4'b1000};
      vecs[9]  = '{4'b0010, 4'b0010, 1'b0, 1'b1, 20'h00200, 8'h11, 4'b0000, 4'b1010};
      vecs[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 20'h00000, 8'h00, 4'b0000, 4'b1010};
      for (int p = 0; p < NUM_REQ; p++) set_port(p, 0, 0, base(p), 8'(8'h10 + p));
      for (int i = 0; i < 11; i++) begin
         port_rd_req = vecs[i].rd;
         port_wr_ena = vecs[i].wr;
         tick();
         check($sformatf("vec%0d_ram_rd", i),   ram_rd,    vecs[i].exp_rd);
         check($sformatf("vec%0d_ram_wena", i), ram_wena,  vecs[i].exp_wena);
         if (vecs[i].exp_rd || vecs[i].exp_wena)
            check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].exp_addr);
         if (vecs[i].exp_wena)
            check($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].exp_wdata);
         check($sformatf("vec%0d_busy", i), port_busy, vecs[i].exp_busy);
         check($sformatf("vec%0d_err", i),  port_err,  vecs[i].exp_err);
      end
      repeat (6) tick();

      // ---- Z80 read on an idle system
      do_reset();
      set_port(PORT_Z80, 1, 0, 20'h12345, 8'h00);
      tick();
      check("z80_ram_rd", ram_rd, 1);
      check("z80_ram_wena", ram_wena, 0);
      check("z80_ram_addr", ram_addr, 20'h12345);
      tick();
      check("z80_ram_rd_one_cycle", ram_rd, 0);
      tick();
      check("z80_rdy_not_early", port_rd_rdy, 0);
      tick();
      check("z80_rdy", port_rd_rdy, 4'b0001);
      check("z80_data", port_rd_data, 8'hA5);
      tick();
      check("z80_rdy_one_shot", port_rd_rdy, 0);

      // ---- contention: ports 0,1,2 together
      set_port(PORT_Z80,  1, 0, 20'h00500, 8'h00);
      set_port(PORT_BLIT, 1, 0, 20'h00501, 8'h00);
      set_port(PORT_DMA,  1, 0, 20'h00502, 8'h00);
      tick();
      check("cont_cmd0_rd", ram_rd, 1);
      check("cont_cmd0_addr", ram_addr, 20'h00500);
      check("cont_busy0", port_busy, 4'b0110);
      tick();
      check("cont_cmd1_rd", ram_rd, 1);
      check("cont_cmd1_addr", ram_addr, 20'h00501);
      check("cont_busy1", port_busy, 4'b0100);
      tick();
      check("cont_cmd2_rd", ram_rd, 1);
      check("cont_cmd2_addr", ram_addr, 20'h00502);
      check("cont_busy2", port_busy, 4'b0000);
      tick();
      check("cont_rdy0", port_rd_rdy, 4'b0001);
      check("cont_data0", port_rd_data, 8'h61);
      tick();
      check("cont_rdy1", port_rd_rdy, 4'b0010);
      check("cont_data1", port_rd_data, 8'h62);
      tick();
      check("cont_rdy2", port_rd_rdy, 4'b0100);
      check("cont_data2", port_rd_data, 8'h63);
      tick();
      check("cont_rdy_done", port_rd_rdy, 0);

      // ---- overflow: second pulse on pending port 2 while Z80 wins
      do_reset();
      set_port(PORT_Z80, 1, 0, 20'h00600, 8'h00);
      set_port(PORT_DMA, 1, 0, 20'h00602, 8'h00);
      tick();
      check("ovf_cmd0_addr", ram_addr, 20'h00600);
      check("ovf_busy0", port_busy, 4'b0100);
      set_port(PORT_Z80, 1, 0, 20'h00610, 8'h00);
      set_port(PORT_DMA, 1, 0, 20'h006FF, 8'h00);
      tick();
      check("ovf_cmd1_addr", ram_addr, 20'h00610);
      check("ovf_err", port_err, 4'b0100);
      check("ovf_busy1", port_busy, 4'b0100);
      tick();
      check("ovf_cmd2_rd", ram_rd, 1);
      check("ovf_cmd2_addr", ram_addr, 20'h00602);
      check("ovf_busy2", port_busy, 4'b0000);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ram_rd && ram_addr == 20'h006FF) bad++;
         if (i == 2) begin
            check("ovf_port2_rdy", port_rd_rdy, 4'b0100);
            check("ovf_port2_data", port_rd_data, 8'h77);
         end
      end
      check("ovf_dropped_never_issued", bad, 0);
      check("ovf_err_sticky", port_err, 4'b0100);

      // ---- write then read to the same address
      set_port(PORT_BLIT, 0, 1, 20'h00010, 8'h3C);
      tick();
      check("wr_rd_wena", ram_wena, 1);
      check("wr_rd_waddr", ram_addr, 20'h00010);
      check("wr_rd_wdata", ram_wdata, 8'h3C);
      set_port(PORT_Z80, 1, 0, 20'h00010, 8'h00);
      tick();
      check("wr_rd_rd", ram_rd, 1);
      check("wr_rd_raddr", ram_addr, 20'h00010);
      repeat (3) tick();
      check("wr_rd_rdy", port_rd_rdy, 4'b0001);
      check("wr_rd_data", port_rd_data, 8'h3C);

      // ---- round-robin fairness: ports 1..3 re-pulse on their rd_rdy
      do_reset();
      for (int p = 1; p < NUM_REQ; p++) begin
         set_port(p, 1, 0, base(p), 8'h00);
         cnt[p] = 0;
      end
      cnt[0] = 0;
      grants = 0;
      pulses = 3;
      budget = 400;
      while (grants < 30 && budget > 0) begin
         tick();
         budget--;
         if (ram_rd) begin
            order.push_back(int'(ram_addr[11:8]) - 1);
            grants++;
         end
         for (int p = 1; p < NUM_REQ; p++) begin
            if (port_rd_rdy[p] && pulses < 30) begin
               set_port(p, 1, 0, base(p), 8'h00);
               pulses++;
            end
         end
      end
      check("rr_grants_before_timeout", grants, 30);
      foreach (order[i]) begin
         check($sformatf("rr_order%0d", i), order[i], (i % 3) + 1);
         if (order[i] >= 0 && order[i] < NUM_REQ) cnt[order[i]]++;
      end
      check("rr_cnt_blit", cnt[PORT_BLIT], 10);
      check("rr_cnt_dma",  cnt[PORT_DMA],  10);
      check("rr_cnt_aux",  cnt[PORT_AUX],  10);
      check("rr_cnt_z80",  cnt[PORT_Z80],  0);
      repeat (8) tick();

      // ---- randomized run against the reference model
      do_reset();
      ref_mem = ram_mem;
      for (int p = 0; p < NUM_REQ; p++) mpend[p] = '{0, 0, '0, '0};
      merr    = '0;
      last_nz = NUM_REQ - 1;
      rspq.delete();
      for (int n = 0; n < 406; n++) begin
         mreq_t eff [NUM_REQ];
         mreq_t inc [NUM_REQ];
         bit    inc_v [NUM_REQ];
         int    win, q, r;
         bit    was;
         rsp_t  rs;
         bit    exp_rd, exp_wr;
         logic [19:0] exp_a;
         logic [7:0]  exp_d;
         logic [3:0]  exp_rdy, exp_busy;
         logic [7:0]  exp_rdata;

         for (int p = 0; p < NUM_REQ; p++) begin
            bit rd, wr;
            r  = $urandom_range(0, 99);
            rd = 0;
            wr = 0;
            if (n < 400) begin
               if (p == 0) begin
                  rd = (r < 8);
                  wr = (r >= 8 && r < 12);
               end else begin
                  rd = (r < 15) || (r >= 25 && r < 28);
                  wr = (r >= 15 && r < 28);
               end
            end
            set_port(p, rd, wr, 20'h00200 + 20'($urandom_range(0, 15)), 8'($urandom));
            inc_v[p] = rd | wr;
            inc[p]   = '{1, wr, port_addr[p*ADDR_W +: ADDR_W], port_wdata[p*DATA_W +: DATA_W]};
            eff[p]   = mpend[p].vld ? mpend[p] : (inc_v[p] ? inc[p] : '{0, 0, '0, '0});
         end

         win = -1;
         if (eff[0].vld) win = 0;
         else begin
            for (int k = 1; k < NUM_REQ; k++) begin
               q = ((last_nz - 1 + k) % (NUM_REQ - 1)) + 1;
               if (win < 0 && eff[q].vld) win = q;
            end
            if (win > 0) last_nz = win;
         end

         exp_rd = 0;
         exp_wr = 0;
         exp_a  = '0;
         exp_d  = '0;
         if (win >= 0) begin
            exp_a = eff[win].addr;
            exp_d = eff[win].wd;
            if (eff[win].wr) begin
               exp_wr = 1;
               ref_mem[exp_a] = exp_d;
            end else begin
               exp_rd  = 1;
               rs.at   = cyc + RL + 2;
               rs.port = win;
               rs.data = ref_peek(exp_a);
               rspq.push_back(rs);
            end
         end

         for (int p = 0; p < NUM_REQ; p++) begin
            was = mpend[p].vld;
            if (p == win && was) mpend[p].vld = 0;
            if (inc_v[p]) begin
               if (was && p != win) merr[p] = 1;
               else if (!(p == win && !was)) mpend[p] = inc[p];
            end
            if (port_rd_req[p] && port_wr_ena[p]) merr[p] = 1;
         end

         tick();

         check("rnd_ram_rd", ram_rd, exp_rd);
         check("rnd_ram_wena", ram_wena, exp_wr);
         if (exp_rd || exp_wr) check("rnd_ram_addr", ram_addr, exp_a);
         if (exp_wr) check("rnd_ram_wdata", ram_wdata, exp_d);
         exp_busy = '0;
         for (int p = 0; p < NUM_REQ; p++) exp_busy[p] = mpend[p].vld;
         check("rnd_busy", port_busy, exp_busy);
         check("rnd_err", port_err, merr);
         exp_rdy   = '0;
         exp_rdata = '0;
         if (rspq.size() > 0 && rspq[0].at == cyc) begin
            rs        = rspq.pop_front();
            exp_rdy   = 4'(1 << rs.port);
            exp_rdata = rs.data;
         end
         check("rnd_rd_rdy", port_rd_rdy, exp_rdy);
         if (exp_rdy != 0) check("rnd_rd_data", port_rd_data, exp_rdata);
      end
      check("rnd_all_responses_seen", rspq.size(), 0);

      // ---- reset while a read is in flight
      set_port(PORT_Z80, 1, 0, 20'h00700, 8'h00);
      tick();
      check("rst_mid_ram_rd", ram_rd, 1);
      tick();
      reset = 1'b1;
      #1;
      check_all_zero("rst_mid_async");
      repeat (2) @(posedge GPU_CLK);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("rst_mid_no_rdy%0d", i), port_rd_rdy, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
